// File: rtl/sar_conv_ctrl.sv
// SAR conversion controller: periodic cnvst generation, eoc edge capture,
// and a show-ahead result FIFO drained over valid/ready.
module sar_conv_ctrl #(
  parameter int RES       = 10,
  parameter int PERIOD    = 64,
  parameter int CNVST_LEN = 2,
  parameter int TIMEOUT   = 48,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr_err,
  input  logic [RES-1:0]           sar,
  input  logic                     eoc,
  output logic                     cnvst,
  output logic                     busy,
  output logic [RES-1:0]           dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     overflow,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   level
);

  // state    | meaning
  // IDLE     | no conversion scheduled, waiting for en
  // START    | cnvst high for CNVST_LEN clocks
  // WAIT_EOC | waiting for eoc rising edge, bounded by TIMEOUT
  // HOLD     | idle remainder of the conversion period

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PERIOD);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (PERIOD < CNVST_LEN + TIMEOUT + 2) begin : g_bad_period
    $error("PERIOD too short for CNVST_LEN + TIMEOUT");
  end
  if (CNVST_LEN < 1) begin : g_bad_cnvst_len
    $error("CNVST_LEN must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_EOC, HOLD} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pcnt;
  logic [TW-1:0]   tcnt;
  logic            eoc_q;
  logic            eoc_edge;
  logic            tmo_hit;

  logic [RES-1:0]  mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            full, push, pop, ovf_set;

  always_comb begin
    state_nxt = state;
    eoc_edge  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE:     if (en) state_nxt = START;
      START:    if (pcnt == PW'(CNVST_LEN - 1)) state_nxt = WAIT_EOC;
      WAIT_EOC: begin
        eoc_edge = eoc & ~eoc_q;
        tmo_hit  = ~eoc_edge && (tcnt == TW'(TIMEOUT - 1));
        if (eoc_edge || tmo_hit) state_nxt = HOLD;
      end
      HOLD:     if (pcnt == PW'(PERIOD - 1)) state_nxt = en ? START : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy = (state == START) || (state == WAIT_EOC);

  // eoc_q resets high so an eoc already asserted at release is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnvst <= 1'b0;
      pcnt  <= '0;
      tcnt  <= '0;
      eoc_q <= 1'b1;
    end else begin
      state <= state_nxt;
      cnvst <= (state_nxt == START);
      eoc_q <= eoc;
      if (state_nxt == START && state != START) pcnt <= '0;
      else if (pcnt == PW'(PERIOD - 1))         pcnt <= '0;
      else                                      pcnt <= pcnt + 1'b1;
      if (state_nxt == WAIT_EOC && state != WAIT_EOC) tcnt <= '0;
      else if (state == WAIT_EOC)                     tcnt <= tcnt + 1'b1;
    end
  end

  // A full FIFO still accepts a word when the head is popped in the same cycle
  assign full       = (level == (AW + 1)'(DEPTH));
  assign dout_valid = (level != '0);
  assign pop        = dout_valid & dout_ready;
  assign push       = eoc_edge & (~full | pop);
  assign ovf_set    = eoc_edge & full & ~pop;
  assign dout       = dout_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sar;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl: reset, period, capture latency, FIFO
// overflow and full-with-pop, timeout, and mid-conversion reset.
module tb_sar_conv_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, clr_err, eoc, dout_ready;
  logic [9:0] sar, dout;
  logic       cnvst, busy, dout_valid, overflow, timeout_err;
  logic [2:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int max_level = 0;
  int s_prev, r;

  always #5 clk = ~clk;

  sar_conv_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .sar(sar), .eoc(eoc),
    .cnvst(cnvst), .busy(busy), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .overflow(overflow), .timeout_err(timeout_err),
    .level(level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnvst"},  32'(cnvst), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_dout"},   32'(dout), 0);
    chk({tag, "_valid"},  32'(dout_valid), 0);
    chk({tag, "_ovf"},    32'(overflow), 0);
    chk({tag, "_tmo"},    32'(timeout_err), 0);
    chk({tag, "_level"},  32'(level), 0);
  endtask

  task automatic wait_cnvst(output int rise);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!cnvst && k < 200);
    chk("cnvst_seen", 32'(cnvst), 1);
    rise = cyc;
  endtask

  task automatic conv(input logic [9:0] val, input int dly, input bit rdy_edge, output int rise);
    wait_cnvst(rise);
    tick();
    tick();
    repeat (dly) tick();
    eoc = 1'b1;
    sar = val;
    if (rdy_edge) dout_ready = 1'b1;
    tick();
    eoc = 1'b0;
    if (rdy_edge) dout_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; clr_err = 1'b0; eoc = 1'b0; sar = '0; dout_ready = 1'b0;

    // reset and single conversion
    repeat (3) tick();
    chk_zero("rst");
    en  = 1'b1;
    rst = 1'b1;
    tick();
    chk("t1_cnvst_s0", 32'(cnvst), 1);
    chk("t1_busy_s0", 32'(busy), 1);
    s_prev = cyc;
    tick();
    chk("t1_cnvst_s1", 32'(cnvst), 1);
    tick();
    chk("t1_cnvst_s2", 32'(cnvst), 0);
    chk("t1_busy_s2", 32'(busy), 1);
    repeat (12) tick();
    eoc = 1'b1;
    sar = 10'h2A5;
    chk("t1_valid_pre", 32'(dout_valid), 0);
    tick();
    eoc = 1'b0;
    chk("t1_valid", 32'(dout_valid), 1);
    chk("t1_dout", 32'(dout), 32'h2A5);
    chk("t1_level", 32'(level), 1);
    chk("t1_busy_done", 32'(busy), 0);

    // periodic rate with continuous draining
    dout_ready = 1'b1;
    max_level = 0;
    for (int k = 0; k < 5; k++) begin
      conv(10'(256 + k), 12, 1'b0, r);
      chk("t2_period", 32'(r - s_prev), 64);
      s_prev = r;
      chk("t2_dout", 32'(dout), 32'(256 + k));
      chk("t2_level", 32'(level), 1);
    end
    tick();
    chk("t2_level_end", 32'(level), 0);
    chk("t2_max_level", 32'(max_level), 1);
    chk("t2_ovf", 32'(overflow), 0);
    dout_ready = 1'b0;

    // overflow with a stalled consumer
    for (int k = 1; k <= 5; k++) begin
      conv(10'(k), 12, 1'b0, r);
      if (k == 4) begin
        chk("t3_level4", 32'(level), 4);
        chk("t3_ovf4", 32'(overflow), 0);
      end
    end
    chk("t3_level", 32'(level), 4);
    chk("t3_ovf", 32'(overflow), 1);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", 32'(dout), 32'(i + 1));
      tick();
    end
    chk("t3_empty", 32'(level), 0);
    dout_ready = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);

    // full FIFO with a pop in the capture cycle
    for (int k = 0; k < 4; k++) conv(10'(16 + k), 12, 1'b0, r);
    chk("t4_full", 32'(level), 4);
    conv(10'h014, 12, 1'b1, r);
    chk("t4_level", 32'(level), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head", 32'(dout), 32'h011);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", 32'(dout), 32'(17 + i));
      tick();
    end
    chk("t4_empty", 32'(level), 0);

    // timeout
    wait_cnvst(s_prev);
    tick();
    tick();
    repeat (47) tick();
    chk("t5_tmo_pre", 32'(timeout_err), 0);
    chk("t5_busy_last", 32'(busy), 1);
    tick();
    chk("t5_tmo", 32'(timeout_err), 1);
    chk("t5_level", 32'(level), 0);
    chk("t5_busy", 32'(busy), 0);

    // mid-conversion reset and stale eoc
    dout_ready = 1'b0;
    conv(10'h3FF, 12, 1'b0, r);
    chk("t5_period", 32'(r - s_prev), 64);
    chk("t6_level_pre", 32'(level), 1);
    chk("t6_tmo_sticky", 32'(timeout_err), 1);
    wait_cnvst(r);
    tick();
    tick();
    repeat (5) tick();
    chk("t6_busy_pre", 32'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("t6_async");
    eoc = 1'b1;
    sar = 10'h155;
    tick();
    tick();
    rst = 1'b1;
    wait_cnvst(r);
    tick();
    tick();
    repeat (20) tick();
    chk("t6_stale_level", 32'(level), 0);
    chk("t6_stale_valid", 32'(dout_valid), 0);
    eoc = 1'b0;
    tick();
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    chk("t6_cap_level", 32'(level), 1);
    chk("t6_cap_dout", 32'(dout), 32'h155);
    chk("t6_tmo_clr", 32'(timeout_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
